collector: RTL
==============

# collector

Output-side deskewer for the 4x4 systolic array: the mirror of the input dripper. The array's bottom edge produces four 32-bit lanes in diagonal (skewed) order. This block samples those lanes over a fixed 7-cycle window and reassembles them into a registered, row/column-addressed 4x4 result matrix. It then signals completion with a one-cycle pulse and holds the matrix until the next collection.

## Interface
Parameters:
- `WIDTH`, default 32: element width in bits. Array size is fixed at 4x4.

Ports:
- `clk`  in  1: single clock; all state updates on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a collection. Sampled only in IDLE or DONE.
- `q1`, `q2`, `q3`, `q4`  in  WIDTH each: skewed output lanes, one per matrix column (lane j = column j).
- `o11` .. `o44`  out  WIDTH each: result matrix, where `oRC` is row R, column C.
- `busy`  out  1: high while collecting.
- `valid`  out  1: high while `o*` holds a complete matrix.
- `done`  out  1: one-cycle pulse when a matrix completes.

## Operation
- States: IDLE, COLLECT, DONE. Internal counter `cnt` is 3 bits, range 0..6.
- Reset: state=IDLE, `cnt`=0, all `o*`=0, `busy`=0, `valid`=0, `done`=0.
- IDLE:
  - `start`=1 → COLLECT, `cnt`=0, `valid`=0, `busy`=1.
  - Otherwise hold all outputs.
- COLLECT, each edge:
  - For each lane j (1..4), let r = `cnt` − (j−1).
  - If 0 ≤ r ≤ 3, capture `qj` into row r+1, column j. Otherwise lane j is ignored, whatever value it carries.
  - If `cnt`=6 → DONE. Else `cnt`++.
  - `start` is ignored while in COLLECT.
- Capture window per column, in `cnt` values:
  - Column 1: cnt 0..3.
  - Column 2: cnt 1..4.
  - Column 3: cnt 2..5.
  - Column 4: cnt 3..6.
- DONE (exactly one cycle): `done`=1, `valid`=1, `busy`=0.
  - `start`=1 → COLLECT immediately (back-to-back collections); `valid` drops on that edge.
  - Else → IDLE with `valid` held at 1.
- `o*` registers not yet overwritten during a collection keep stale data. Consumers read `o*` only when `valid`=1.
- Width rule: values are captured verbatim, with no arithmetic and no truncation.

## Timing
- Let E0 be the edge where `start` is sampled in IDLE or DONE.
- Lane sampling happens at edges E1..E7 (`cnt` = 0..6 during the preceding cycles).
- Element (R,C) is sampled at edge E(R+C−1). Example: `o11` at E1, `o44` at E7.
- After E7: `done`=1 and `valid`=1 for the cycle E7..E8, and `busy`=0.
- Busy window: `busy`=1 from after E0 until after E7 (7 cycles).
- Minimum start-to-start period is 8 cycles, with `start` asserted in the DONE cycle.
- Reset mid-COLLECT: at the next edge, the block goes to IDLE, the partial matrix is discarded, and `o*` is cleared to 0. No `done` pulse is produced.
- `rst` and `start` asserted on the same edge: reset wins.

## Structure
- Shared package `systolic_pkg`:
  - `ARR_N`=4.
  - `SKEW_LEN`=2*ARR_N−1=7.
  - State enum {IDLE, COLLECT, DONE}.
  - Both dripper and collector use it.
- One sub-module, `collect_lane`:
  - Per column: a 4-entry WIDTH register column.
  - Write enable decoded from `cnt` and a constant lane offset.
  - Row index = `cnt` − offset.
  - Instantiated 4 times, with offsets 0..3.
- Top level holds the FSM, `cnt`, and the `busy`/`valid`/`done` logic.

## Test plan
- Identity round trip:
  - Stimulus: feed the diagonal skew of 0xffff·I; lane j = 0xffff only at cnt = 2(j−1), 0 otherwise.
  - Response: `o11`=`o22`=`o33`=`o44`=0xffff, all else 0. `done` high exactly 8 cycles after `start` (E0→E8 window). `busy` high for 7 cycles.
- Indexed matrix:
  - Stimulus: lane j at cnt k carries 0x(R)(C) with R=k−j+2; lanes carry 0xdead outside their window.
  - Response: `oRC`=0x00RC for all 16 elements, and no 0xdead anywhere.
- Back-to-back:
  - Stimulus: assert `start` in the DONE cycle with a second matrix (all elements 0x5).
  - Response: `valid` drops the next cycle. Second `done` arrives 8 cycles after the first. All `o*`=0x5.
- Start ignored:
  - Stimulus: pulse `start` at cnt=3 mid-collection.
  - Response: timing unchanged, and exactly one `done` pulse.
- Reset mid-collection:
  - Stimulus: `rst`=1 at cnt=4.
  - Response: next cycle all `o*`=0, `busy`=`valid`=`done`=0, and no `done` pulse is ever produced. A following `start` completes normally.
- Reset/start collision:
  - Stimulus: `rst` and `start` both high on the same edge.
  - Response: block is in IDLE, `busy`=0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the 4x4 systolic array edge blocks (dripper and collector).
// Array size, skew window length and the common edge-block FSM state type.
// Pure declarations: no logic, no latency, no flow control.
package systolic_pkg;
  localparam int ARR_N    = 4;
  localparam int SKEW_LEN = 2 * ARR_N - 1;

  // Last counter value of a skew window (0-based).
  localparam logic [2:0] CNT_LAST = 3'(SKEW_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;
endpackage

// File: rtl/collect_lane.sv
// One result column: captures its skewed lane into rows 0..3 while cnt is in [OFFSET, OFFSET+3].
// Latency: a sample appears in its row register one edge after it is presented.
// No backpressure: the lane is sampled unconditionally inside its window and ignored outside it.
module collect_lane
  import systolic_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int OFFSET = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [2:0]                   cnt,
  input  logic [WIDTH-1:0]             q,
  output logic [ARR_N-1:0][WIDTH-1:0]  col
);

  localparam logic [3:0] LO = 4'(OFFSET);

  logic [3:0] diff;
  logic       in_win;

  // Row index is cnt - OFFSET; a negative difference wraps to >= 4, so one
  // range test on the upper bits covers both ends of the window.
  always_comb begin
    diff   = {1'b0, cnt} - LO;
    in_win = en && (diff[3:2] == 2'b00);
  end

  // Column storage: cleared by reset, otherwise holds until overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
    end else if (in_win) begin
      col[diff[1:0]] <= q;
    end
  end

endmodule

// File: rtl/collector.sv
// Output deskewer for the 4x4 systolic array: reassembles diagonal lanes into a row/column matrix.
// Latency: 7 sampling edges after start is taken; done pulses for the cycle following the 7th.
// No backpressure: start is accepted only in IDLE/DONE, ignored while collecting; matrix held until next start.
module collector
  import systolic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] q1,
  input  logic [WIDTH-1:0] q2,
  input  logic [WIDTH-1:0] q3,
  input  logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] o11, o12, o13, o14,
  output logic [WIDTH-1:0] o21, o22, o23, o24,
  output logic [WIDTH-1:0] o31, o32, o33, o34,
  output logic [WIDTH-1:0] o41, o42, o43, o44,
  output logic             busy,
  output logic             valid,
  output logic             done
);

  state_t     state;
  logic [2:0] cnt;

  logic [ARR_N-1:0][WIDTH-1:0] lane_in;
  logic [ARR_N-1:0][WIDTH-1:0] col [ARR_N];

  assign lane_in[0] = q1;
  assign lane_in[1] = q2;
  assign lane_in[2] = q3;
  assign lane_in[3] = q4;

  // Control FSM: window counter and the valid flag; reset overrides start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= COLLECT;
            cnt   <= 3'd0;
            valid <= 1'b0;
          end
        end
        COLLECT: begin
          if (cnt == CNT_LAST) begin
            state <= DONE;
            valid <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          if (start) begin
            state <= COLLECT;
            cnt   <= 3'd0;
            valid <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == COLLECT);
  assign done = (state == DONE);

  // Column j samples lane j over cnt = j .. j+3.
  for (genvar c = 0; c < ARR_N; c++) begin : g_lane
    collect_lane #(
      .WIDTH  (WIDTH),
      .OFFSET (c)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (busy),
      .cnt (cnt),
      .q   (lane_in[c]),
      .col (col[c])
    );
  end

  assign o11 = col[0][0];  assign o12 = col[1][0];  assign o13 = col[2][0];  assign o14 = col[3][0];
  assign o21 = col[0][1];  assign o22 = col[1][1];  assign o23 = col[2][1];  assign o24 = col[3][1];
  assign o31 = col[0][2];  assign o32 = col[1][2];  assign o33 = col[2][2];  assign o34 = col[3][2];
  assign o41 = col[0][3];  assign o42 = col[1][3];  assign o43 = col[2][3];  assign o44 = col[3][3];

endmodule
